// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage : writeback stage of the wizardCore 5-stage pipeline.
//
// Retires one instruction per i_valid/o_ready handshake from MEM. ALU results
// are written to the register file in the cycle after accept. Loads wait for
// the data-memory response, which is aligned and sign/zero-extended before the
// write. A load that never gets its response is abandoned after TIMEOUT cycles.
//
// Ports:
//   i_clk, i_reset_n           clock, asynchronous active-low reset
//   i_valid / o_ready          instruction handshake from MEM
//   i_regWrite, i_memToReg     instruction writes rd / instruction is a load
//   i_rd, i_func3, i_addrLo    destination, load type, load byte address [1:0]
//   i_aluResult                ALU result for non-load instructions
//   i_memRspValid/Data         data-memory read response (word aligned)
//   o_wrSig/o_wrReg/o_wrData   register-file write port
//   o_rspErr                   sticky error flag (cleared only by reset)
//   o_retireCnt                count of retired instructions (wraps)
// -----------------------------------------------------------------------------
module wb_stage #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 32
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic             i_regWrite,
   input  logic             i_memToReg,
   input  logic [4:0]       i_rd,
   input  logic [2:0]       i_func3,
   input  logic [1:0]       i_addrLo,
   input  logic [31:0]      i_aluResult,
   input  logic             i_memRspValid,
   input  logic [31:0]      i_memRspData,
   output logic             o_wrSig,
   output logic [4:0]       o_wrReg,
   output logic [31:0]      o_wrData,
   output logic             o_rspErr,
   output logic [CNT_W-1:0] o_retireCnt
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_MEM = 2'd1,
      WRITE    = 2'd2
   } state_t;

   // Last wait cycle index; the counter starts at 0 on accept.
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   // Returns {legal, extended data} for a load of type func3 at byte addr_lo.
   function automatic logic [32:0] align_load(input logic [2:0]  func3,
                                              input logic [1:0]  addr_lo,
                                              input logic [31:0] word);
      logic [7:0]  byte_v;
      logic [15:0] half_v;
      logic [32:0] res_v;
      case (addr_lo)
         2'd0:    byte_v = word[7:0];
         2'd1:    byte_v = word[15:8];
         2'd2:    byte_v = word[23:16];
         default: byte_v = word[31:24];
      endcase
      half_v = addr_lo[1] ? word[31:16] : word[15:0];
      case (func3)
         3'b000:  res_v = {1'b1, {24{byte_v[7]}}, byte_v};
         3'b100:  res_v = {1'b1, 24'd0, byte_v};
         3'b001:  res_v = {~addr_lo[0], {16{half_v[15]}}, half_v};
         3'b101:  res_v = {~addr_lo[0], 16'd0, half_v};
         3'b010:  res_v = {(addr_lo == 2'b00), word};
         default: res_v = {1'b0, 32'd0};
      endcase
      return res_v;
   endfunction

   state_t             state_r,      state_nxt_s;
   logic [7:0]         tmo_cnt_r,    tmo_cnt_nxt_s;
   logic [4:0]         ld_rd_r,      ld_rd_nxt_s;
   logic               ld_we_r,      ld_we_nxt_s;
   logic [2:0]         ld_f3_r,      ld_f3_nxt_s;
   logic [1:0]         ld_alo_r,     ld_alo_nxt_s;
   logic               wr_sig_r,     wr_sig_nxt_s;
   logic [4:0]         wr_reg_r,     wr_reg_nxt_s;
   logic [31:0]        wr_data_r,    wr_data_nxt_s;
   logic               rsp_err_r,    rsp_err_nxt_s;
   logic [CNT_W-1:0]   retire_cnt_r, retire_cnt_nxt_s;
   logic [32:0]        aligned_s;

   assign aligned_s   = align_load(ld_f3_r, ld_alo_r, i_memRspData);
   assign o_ready     = (state_r != WAIT_MEM);
   assign o_wrSig     = wr_sig_r;
   assign o_wrReg     = wr_reg_r;
   assign o_wrData    = wr_data_r;
   assign o_rspErr    = rsp_err_r;
   assign o_retireCnt = retire_cnt_r;

   // Next-state and next-output logic. Outputs are computed for the state
   // being entered so that the registered write port is valid in WRITE.
   always_comb begin
      state_nxt_s      = state_r;
      tmo_cnt_nxt_s    = tmo_cnt_r;
      ld_rd_nxt_s      = ld_rd_r;
      ld_we_nxt_s      = ld_we_r;
      ld_f3_nxt_s      = ld_f3_r;
      ld_alo_nxt_s     = ld_alo_r;
      wr_sig_nxt_s     = 1'b0;
      wr_reg_nxt_s     = wr_reg_r;
      wr_data_nxt_s    = wr_data_r;
      rsp_err_nxt_s    = rsp_err_r;
      retire_cnt_nxt_s = retire_cnt_r;
      case (state_r)
         IDLE, WRITE: begin
            // Any response outside WAIT_MEM is stray.
            if (i_memRspValid) begin
               rsp_err_nxt_s = 1'b1;
            end else begin
               rsp_err_nxt_s = rsp_err_r;
            end
            if (i_valid) begin
               if (i_memToReg) begin
                  ld_rd_nxt_s   = i_rd;
                  ld_we_nxt_s   = i_regWrite;
                  ld_f3_nxt_s   = i_func3;
                  ld_alo_nxt_s  = i_addrLo;
                  tmo_cnt_nxt_s = 8'd0;
                  state_nxt_s   = WAIT_MEM;
               end else begin
                  wr_sig_nxt_s     = i_regWrite && (i_rd != 5'd0);
                  wr_reg_nxt_s     = i_rd;
                  wr_data_nxt_s    = i_aluResult;
                  retire_cnt_nxt_s = retire_cnt_r + CNT_W'(1);
                  state_nxt_s      = WRITE;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         WAIT_MEM: begin
            if (i_memRspValid) begin
               retire_cnt_nxt_s = retire_cnt_r + CNT_W'(1);
               if (aligned_s[32]) begin
                  wr_sig_nxt_s  = ld_we_r && (ld_rd_r != 5'd0);
                  wr_reg_nxt_s  = ld_rd_r;
                  wr_data_nxt_s = aligned_s[31:0];
                  state_nxt_s   = WRITE;
               end else begin
                  // Misaligned or undefined load type: retire without a write.
                  rsp_err_nxt_s = 1'b1;
                  state_nxt_s   = IDLE;
               end
            end else if (tmo_cnt_r == TMO_LAST) begin
               rsp_err_nxt_s    = 1'b1;
               retire_cnt_nxt_s = retire_cnt_r + CNT_W'(1);
               state_nxt_s      = IDLE;
            end else begin
               tmo_cnt_nxt_s = tmo_cnt_r + 8'd1;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State, captured load fields and registered outputs.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_r      <= IDLE;
         tmo_cnt_r    <= 8'd0;
         ld_rd_r      <= 5'd0;
         ld_we_r      <= 1'b0;
         ld_f3_r      <= 3'd0;
         ld_alo_r     <= 2'd0;
         wr_sig_r     <= 1'b0;
         wr_reg_r     <= 5'd0;
         wr_data_r    <= 32'd0;
         rsp_err_r    <= 1'b0;
         retire_cnt_r <= '0;
      end else begin
         state_r      <= state_nxt_s;
         tmo_cnt_r    <= tmo_cnt_nxt_s;
         ld_rd_r      <= ld_rd_nxt_s;
         ld_we_r      <= ld_we_nxt_s;
         ld_f3_r      <= ld_f3_nxt_s;
         ld_alo_r     <= ld_alo_nxt_s;
         wr_sig_r     <= wr_sig_nxt_s;
         wr_reg_r     <= wr_reg_nxt_s;
         wr_data_r    <= wr_data_nxt_s;
         rsp_err_r    <= rsp_err_nxt_s;
         retire_cnt_r <= retire_cnt_nxt_s;
      end
   end

endmodule

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage : self-checking bench for wb_stage. A transaction-level model
// (pending load + age, expected write port) tracks what the outputs must be;
// every cycle the outputs are compared to it, and directed scenarios add
// hand-computed literal expectations. A randomized phase follows.
// -----------------------------------------------------------------------------
module tb_wb_stage;

   localparam int TIMEOUT = 16;
   localparam int CNT_W   = 32;

   logic        i_clk = 1'b0;
   logic        i_reset_n = 1'b0;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic        i_regWrite = 1'b0;
   logic        i_memToReg = 1'b0;
   logic [4:0]  i_rd = 5'd0;
   logic [2:0]  i_func3 = 3'd0;
   logic [1:0]  i_addrLo = 2'd0;
   logic [31:0] i_aluResult = 32'd0;
   logic        i_memRspValid = 1'b0;
   logic [31:0] i_memRspData = 32'd0;
   logic        o_wrSig;
   logic [4:0]  o_wrReg;
   logic [31:0] o_wrData;
   logic        o_rspErr;
   logic [CNT_W-1:0] o_retireCnt;

   int tests = 0;
   int fails = 0;

   wb_stage #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_regWrite(i_regWrite), .i_memToReg(i_memToReg), .i_rd(i_rd),
      .i_func3(i_func3), .i_addrLo(i_addrLo), .i_aluResult(i_aluResult),
      .i_memRspValid(i_memRspValid), .i_memRspData(i_memRspData),
      .o_wrSig(o_wrSig), .o_wrReg(o_wrReg), .o_wrData(o_wrData),
      .o_rspErr(o_rspErr), .o_retireCnt(o_retireCnt)
   );

   always #5 i_clk = ~i_clk;

   // ---------------- reference model ----------------
   // Load result from the rules: access size from func3[1:0], unsigned when
   // func3[2] is set, legal only if the address is a multiple of the size.
   function automatic logic [32:0] ref_load(input logic [2:0] f3, input logic [1:0] a,
                                            input logic [31:0] word);
      int          size;
      int          ai;
      logic [31:0] sh;
      logic [31:0] val;
      logic        legal;
      ai = int'(a);
      sh = word >> (8 * ai);
      case (f3[1:0])
         2'd0:    size = 1;
         2'd1:    size = 2;
         2'd2:    size = 4;
         default: size = 0;
      endcase
      legal = (size != 0) && (f3 != 3'b110) && ((ai % ((size == 0) ? 1 : size)) == 0);
      if (size == 1)      val = f3[2] ? {24'd0, sh[7:0]}  : 32'($signed(sh[7:0]));
      else if (size == 2) val = f3[2] ? {16'd0, sh[15:0]} : 32'($signed(sh[15:0]));
      else                val = sh;
      return {legal, val};
   endfunction

   logic        m_pend = 1'b0;
   int          m_age = 0;
   logic [4:0]  p_rd = 5'd0;
   logic        p_we = 1'b0;
   logic [2:0]  p_f3 = 3'd0;
   logic [1:0]  p_alo = 2'd0;
   logic        e_sig = 1'b0;
   logic [4:0]  e_reg = 5'd0;
   logic [31:0] e_data = 32'd0;
   logic        e_err = 1'b0;
   logic [31:0] e_cnt = 32'd0;
   logic [32:0] m_res;

   assign m_res = ref_load(p_f3, p_alo, i_memRspData);

   // Model update: one retiring instruction at a time, a load holds the stage.
   always @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         m_pend <= 1'b0; m_age <= 0;
         e_sig <= 1'b0; e_reg <= 5'd0; e_data <= 32'd0; e_err <= 1'b0; e_cnt <= 32'd0;
      end else begin
         e_sig <= 1'b0;
         if (m_pend) begin
            if (i_memRspValid) begin
               m_pend <= 1'b0;
               e_cnt  <= e_cnt + 32'd1;
               if (m_res[32]) begin
                  e_sig  <= p_we && (p_rd != 5'd0);
                  e_reg  <= p_rd;
                  e_data <= m_res[31:0];
               end else begin
                  e_err <= 1'b1;
               end
            end else if (m_age + 1 == TIMEOUT) begin
               m_pend <= 1'b0;
               e_err  <= 1'b1;
               e_cnt  <= e_cnt + 32'd1;
            end else begin
               m_age <= m_age + 1;
            end
         end else begin
            if (i_memRspValid) e_err <= 1'b1;
            if (i_valid) begin
               if (i_memToReg) begin
                  m_pend <= 1'b1; m_age <= 0;
                  p_rd <= i_rd; p_we <= i_regWrite; p_f3 <= i_func3; p_alo <= i_addrLo;
               end else begin
                  e_sig  <= i_regWrite && (i_rd != 5'd0);
                  e_reg  <= i_rd;
                  e_data <= i_aluResult;
                  e_cnt  <= e_cnt + 32'd1;
               end
            end
         end
      end
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_model();
      chk("model_ready",  32'(o_ready),     32'(!m_pend));
      chk("model_wrSig",  32'(o_wrSig),     32'(e_sig));
      chk("model_wrReg",  32'(o_wrReg),     32'(e_reg));
      chk("model_wrData", o_wrData,         e_data);
      chk("model_rspErr", 32'(o_rspErr),    32'(e_err));
      chk("model_cnt",    o_retireCnt,      e_cnt);
   endtask

   // Advance to the next falling edge (away from the active edge) and compare.
   task automatic step();
      @(negedge i_clk);
      compare_model();
   endtask

   task automatic idle_in();
      i_valid = 1'b0; i_memToReg = 1'b0; i_regWrite = 1'b0; i_memRspValid = 1'b0;
   endtask

   task automatic set_alu(input logic [4:0] rd, input logic we, input logic [31:0] v);
      i_valid = 1'b1; i_memToReg = 1'b0; i_regWrite = we; i_rd = rd; i_aluResult = v;
   endtask

   task automatic set_load(input logic [4:0] rd, input logic we, input logic [2:0] f3,
                           input logic [1:0] a);
      i_valid = 1'b1; i_memToReg = 1'b1; i_regWrite = we; i_rd = rd;
      i_func3 = f3; i_addrLo = a;
   endtask

   task automatic do_reset();
      i_reset_n = 1'b0;
      #1;
      chk("rst_wrSig",  32'(o_wrSig),  32'd0);
      chk("rst_wrReg",  32'(o_wrReg),  32'd0);
      chk("rst_wrData", o_wrData,      32'd0);
      chk("rst_rspErr", 32'(o_rspErr), 32'd0);
      chk("rst_cnt",    o_retireCnt,   32'd0);
      chk("rst_ready",  32'(o_ready),  32'd1);
      step();
      i_reset_n = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      idle_in();
      i_reset_n = 1'b0;
      step();
      step();
      do_reset();

      // single ALU op
      set_alu(5'd5, 1'b1, 32'hDEADBEEF);
      step(); idle_in();
      chk("alu_sig",  32'(o_wrSig), 32'd1);
      chk("alu_reg",  32'(o_wrReg), 32'd5);
      chk("alu_data", o_wrData,     32'hDEADBEEF);
      chk("alu_cnt",  o_retireCnt,  32'd1);

      // back-to-back ALU ops
      set_alu(5'd1, 1'b1, 32'd11); step();
      chk("b2b1_sig", 32'(o_wrSig), 32'd1); chk("b2b1_reg", 32'(o_wrReg), 32'd1);
      chk("b2b1_rdy", 32'(o_ready), 32'd1);
      set_alu(5'd2, 1'b1, 32'd22); step();
      chk("b2b2_sig", 32'(o_wrSig), 32'd1); chk("b2b2_reg", 32'(o_wrReg), 32'd2);
      chk("b2b2_rdy", 32'(o_ready), 32'd1);
      set_alu(5'd3, 1'b1, 32'd33); step();
      chk("b2b3_sig", 32'(o_wrSig), 32'd1); chk("b2b3_reg", 32'(o_wrReg), 32'd3);
      chk("b2b3_data", o_wrData, 32'd33);   chk("b2b3_cnt", o_retireCnt, 32'd4);
      idle_in(); step();
      chk("b2b_end_sig", 32'(o_wrSig), 32'd0);
      chk("b2b_hold_reg", 32'(o_wrReg), 32'd3);

      // LB, addrLo 3, response on the 4th wait cycle
      set_load(5'd7, 1'b1, 3'b000, 2'd3); step(); idle_in();
      chk("lb_wait_rdy", 32'(o_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("lb_wait_rdy", 32'(o_ready), 32'd0);
      end
      i_memRspValid = 1'b1; i_memRspData = 32'h80FF_1234;
      step(); i_memRspValid = 1'b0;
      chk("lb_sig",  32'(o_wrSig), 32'd1);
      chk("lb_reg",  32'(o_wrReg), 32'd7);
      chk("lb_data", o_wrData,     32'hFFFFFF80);
      chk("lb_cnt",  o_retireCnt,  32'd5);

      // LHU, addrLo 2
      set_load(5'd8, 1'b1, 3'b101, 2'd2); step(); idle_in(); step();
      i_memRspValid = 1'b1; i_memRspData = 32'h80FF_1234;
      step(); i_memRspValid = 1'b0;
      chk("lhu_sig",  32'(o_wrSig), 32'd1);
      chk("lhu_data", o_wrData,     32'h000080FF);
      chk("lhu_cnt",  o_retireCnt,  32'd6);

      // LW misaligned
      set_load(5'd9, 1'b1, 3'b010, 2'd1); step(); idle_in();
      i_memRspValid = 1'b1; i_memRspData = 32'hCAFEF00D;
      step(); i_memRspValid = 1'b0;
      chk("lw_mis_sig", 32'(o_wrSig),  32'd0);
      chk("lw_mis_err", 32'(o_rspErr), 32'd1);
      chk("lw_mis_cnt", o_retireCnt,   32'd7);
      chk("lw_mis_rdy", 32'(o_ready),  32'd1);
      do_reset();

      // stray response in IDLE
      i_memRspValid = 1'b1; step(); i_memRspValid = 1'b0;
      chk("stray_err", 32'(o_rspErr), 32'd1);
      chk("stray_sig", 32'(o_wrSig),  32'd0);
      chk("stray_cnt", o_retireCnt,   32'd0);
      do_reset();

      // timeout
      set_load(5'd10, 1'b1, 3'b010, 2'd0); step(); idle_in();
      for (int i = 0; i < TIMEOUT; i++) begin
         chk("tmo_wait_rdy", 32'(o_ready),  32'd0);
         chk("tmo_wait_err", 32'(o_rspErr), 32'd0);
         step();
      end
      chk("tmo_rdy", 32'(o_ready),  32'd1);
      chk("tmo_err", 32'(o_rspErr), 32'd1);
      chk("tmo_sig", 32'(o_wrSig),  32'd0);
      chk("tmo_cnt", o_retireCnt,   32'd1);
      do_reset();

      // write to x0
      set_alu(5'd0, 1'b1, 32'h12345678); step(); idle_in();
      chk("x0_sig", 32'(o_wrSig), 32'd0);
      chk("x0_cnt", o_retireCnt,  32'd1);

      // reset in the middle of a load, later response must not write
      set_load(5'd11, 1'b1, 3'b010, 2'd0); step(); idle_in(); step();
      do_reset();
      i_memRspValid = 1'b1; i_memRspData = 32'h55AA55AA;
      step(); i_memRspValid = 1'b0;
      chk("rstld_sig", 32'(o_wrSig), 32'd0);
      chk("rstld_cnt", o_retireCnt,  32'd0);
      do_reset();

      // randomized phase
      for (int c = 0; c < 4000; c++) begin
         i_valid       = ($urandom_range(0, 2) != 0);
         i_memToReg    = 1'($urandom_range(0, 1));
         i_regWrite    = ($urandom_range(0, 3) != 0);
         i_rd          = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
         i_func3       = 3'($urandom);
         i_addrLo      = 2'($urandom);
         i_aluResult   = $urandom;
         i_memRspData  = $urandom;
         i_memRspValid = m_pend ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 60) == 0);
         if ($urandom_range(0, 300) == 0) begin
            do_reset();
         end else begin
            step();
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
